io_input_debouncer: RTL and testbench
=====================================

Name: io_input_debouncer

Overview:
- Input-side counterpart to the LED output path.
- Takes asynchronous push-button/DIP inputs from the IO board and synchronises each one into clk.
- Debounces each input with a per-bit stability counter and reports single-cycle press/release pulses.
- Holds presses in a sticky event register with a valid/ack handshake, so slow consumers (menu FSMs, LED pattern selectors) never miss a press.

Parameters:
- NUM_INPUTS, 5, number of independent inputs (5 IO buttons; 24 for the DIP bank).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before accepting a change (10 ms at 100 MHz); must be >= 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- raw_in  input  NUM_INPUTS  asynchronous inputs, active-high.
- stable  output  NUM_INPUTS  debounced level per input.
- press  output  NUM_INPUTS  one-cycle pulse on the accepted 0->1 change.
- release  output  NUM_INPUTS  one-cycle pulse on the accepted 1->0 change.
- event_valid  output  1  high while any bit of event_mask is set.
- event_mask  output  NUM_INPUTS  sticky record of presses since the last ack.
- event_ack  input  1  consumer acknowledge; clears the latched presses.

Behaviour:
- Reset (rst==0 at a clk edge): sync stages, stable, counters, press, release, event_mask and event_valid all go to 0.
  - An input already high when reset releases is debounced normally and produces a press.
- Synchroniser: two flops per bit (sync1 <= raw_in; s <= sync1). No other logic reads raw_in.
- Per-bit counter, evaluated each edge:
  - If s == stable: cnt <= 0, no pulse.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s; cnt <= 0; press or release pulse for exactly one cycle, in the same edge as the stable change.
  - Else: cnt <= cnt+1.
- Glitch rejection: any cycle where s returns to stable resets cnt to 0. A bounce shorter than DEBOUNCE_CYCLES never changes stable.
- Latency: edge 0 is the first edge sampling the new raw value, held steady. stable and the pulse update at edge DEBOUNCE_CYCLES+1.
- press and release are registered and mutually exclusive per bit. Bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1, and it is cleared on acceptance.
- Event latch:
  - No ack: event_mask <= event_mask | press.
  - event_ack && event_valid: event_mask <= press. A press in the ack cycle is retained, not lost.
  - event_ack while !event_valid is ignored.
- event_valid is registered and equals |event_mask, updated in the same edge as event_mask.
- Releases are never latched into event_mask.
- Reset mid-count discards partial counts; no pulse is emitted for an unfinished debounce.

Decomposition:
- Shared package io_input_pkg:
  - NUM_IO_BUTTONS=5, NUM_IO_DIPS=24.
  - CLK_HZ=100000000.
  - DEBOUNCE_10MS=1000000.
- Sub-module debounce_bit: the synchroniser, counter and stable/press/release logic for one input, instantiated NUM_INPUTS times via generate.
- The top level owns only the event latch and handshake.

Test Plan (DEBOUNCE_CYCLES=4, NUM_INPUTS=5):
- Clean press: raw_in 0->1 before edge 0, held -> stable[0]=1 and press[0]=1 at edge 5 only; event_valid=1 and event_mask=5'b00001 from edge 6.
- Bounce: raw_in[1] toggles 1,0,1,0 with a 3-cycle high, then held high -> no pulse during bounce; press[1] exactly once, 5 edges after the final rising edge is sampled.
- Release: after the clean press, raw_in[0] 1->0 held -> release[0] one cycle at edge 5, stable[0]=0; event_mask unchanged.
- Ack collision: event_mask=00001, event_ack asserted in the same cycle press[2] pulses -> event_mask=00100, event_valid stays 1. Ack again with no press -> event_mask=0, event_valid=0.
- Multi-bit: raw_in 00000->11010 simultaneously -> press=11010 in one cycle, event_mask=11010.
- Reset mid-count: raw_in[3] high for 3 edges, then rst=0 for one edge with raw still high -> all outputs 0; press[3] asserts 6 edges after rst returns high (2 sync + 4 count).

Source files
------------

// File: rtl/io_input_pkg.sv
// Shared constants for the IO-board input path (buttons, DIP bank, debounce timing).
package io_input_pkg;

  localparam int NUM_IO_BUTTONS = 5;
  localparam int NUM_IO_DIPS    = 24;
  localparam int CLK_HZ         = 100000000;
  localparam int DEBOUNCE_10MS  = 1000000;

endpackage

// File: rtl/debounce_bit.sv
// One input lane: two-flop synchroniser, stability counter, debounced level and edge pulses.
module debounce_bit
  import io_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic stable,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 s;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-flop synchroniser: the only reader of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw_in;
      s     <= sync1;
    end
  end

  // Any cycle agreeing with the accepted level restarts the count, so bounces never accumulate
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= '0;
      stable        <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else if (s == stable) begin
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt           <= '0;
      stable        <= s;
      press         <= s;
      release_pulse <= ~s;
    end else begin
      cnt           <= cnt + 1'b1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/io_input_debouncer.sv
// Debounced button/DIP inputs with a sticky press register and valid/ack handshake.
module io_input_debouncer
  import io_input_pkg::*;
#(
  parameter int NUM_INPUTS      = NUM_IO_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] stable,
  output logic [NUM_INPUTS-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [NUM_INPUTS-1:0] release_pulse,
  output logic                  event_valid,
  output logic [NUM_INPUTS-1:0] event_mask,
  input  logic                  event_ack
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_INPUTS-1:0] mask_next;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw_in[i]),
      .stable       (stable[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i])
    );
  end

  // A press landing in the ack cycle survives into the fresh mask
  always_comb begin
    mask_next = event_mask | press;
    if (event_ack && event_valid) begin
      mask_next = press;
    end else begin
      mask_next = event_mask | press;
    end
  end

  // Sticky event register; valid tracks the mask in the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      event_mask  <= '0;
      event_valid <= 1'b0;
    end else begin
      event_mask  <= mask_next;
      event_valid <= |mask_next;
    end
  end

endmodule

// File: tb/tb_io_input_debouncer.sv
// Self-checking bench: per-cycle scoreboard against a behavioural model plus directed latency checks.
module tb_io_input_debouncer;

  localparam int N  = 5;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_in;
  logic         event_ack;
  logic [N-1:0] stable, press, release_pulse, event_mask;
  logic         event_valid;

  io_input_debouncer #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .stable       (stable),
    .press        (press),
    .release_pulse(release_pulse),
    .event_valid  (event_valid),
    .event_mask   (event_mask),
    .event_ack    (event_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] stable;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] mask;
    logic         valid;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // behavioural model: run length of disagreement between synchronised input and accepted level
  logic [N-1:0] m_sync1, m_s, m_stable, m_press, m_rel, m_mask;
  logic         m_valid;
  int           m_run[N];

  int rel_edge;
  int press_cnt[N], press_at[N], rel_cnt[N], rel_at[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    rel_edge = 0;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; press_at[i] = -1; rel_cnt[i] = 0; rel_at[i] = -1;
    end
  endtask

  task automatic step();
    obs_t         e;
    obs_t         o;
    logic [N-1:0] np, nr, acc;
    @(posedge clk);
    if (!rst) begin
      m_sync1 = '0; m_s = '0; m_stable = '0; m_press = '0; m_rel = '0;
      m_mask = '0; m_valid = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      np = '0; nr = '0; acc = m_stable;
      for (int i = 0; i < N; i++) begin
        if (m_s[i] !== m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            acc[i] = m_s[i];
            if (m_s[i]) np[i] = 1'b1; else nr[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (event_ack && m_valid) m_mask = m_press;
      else m_mask = m_mask | m_press;
      m_valid  = (m_mask != '0);
      m_press  = np;
      m_rel    = nr;
      m_stable = acc;
      m_s      = m_sync1;
      m_sync1  = raw_in;
    end
    e = '{stable: m_stable, press: m_press, rel: m_rel, mask: m_mask, valid: m_valid};
    exp_q.push_back(e);
    #1;
    o = '{stable: stable, press: press, rel: release_pulse, mask: event_mask, valid: event_valid};
    e = exp_q.pop_front();
    check("cycle", 64'(o), 64'(e));
    for (int i = 0; i < N; i++) begin
      if (press[i] === 1'b1) begin press_cnt[i]++; press_at[i] = rel_edge; end
      if (release_pulse[i] === 1'b1) begin rel_cnt[i]++; rel_at[i] = rel_edge; end
    end
    rel_edge++;
  endtask

  initial begin
    rst = 1'b0; raw_in = '0; event_ack = 1'b0;
    clear_obs();
    step(); step();
    check("reset_outputs", 64'({stable, press, release_pulse, event_mask, event_valid}), 64'd0);
    rst = 1'b1;
    repeat (2) step();

    // clean press on bit 0
    raw_in[0] = 1'b1; clear_obs();
    repeat (8) step();
    check("clean_press_edge", 64'(press_at[0]), 64'd5);
    check("clean_press_count", 64'(press_cnt[0]), 64'd1);
    check("clean_mask", 64'({event_valid, event_mask}), 64'({1'b1, 5'b00001}));

    // bounce on bit 1 then hold
    clear_obs();
    raw_in[1] = 1'b1; step();
    raw_in[1] = 1'b0; step();
    raw_in[1] = 1'b1; repeat (3) step();
    raw_in[1] = 1'b0; step();
    check("bounce_no_pulse", 64'(press_cnt[1]), 64'd0);
    raw_in[1] = 1'b1; clear_obs();
    repeat (8) step();
    check("bounce_press_edge", 64'(press_at[1]), 64'd5);
    check("bounce_press_count", 64'(press_cnt[1]), 64'd1);

    // release of bit 0 leaves the mask alone
    raw_in[0] = 1'b0; clear_obs();
    repeat (8) step();
    check("release_edge", 64'(rel_at[0]), 64'd5);
    check("release_count", 64'(rel_cnt[0]), 64'd1);
    check("release_stable", 64'(stable), 64'(5'b00010));
    check("release_mask", 64'(event_mask), 64'(5'b00011));

    // ack collides with press on bit 2
    raw_in[2] = 1'b1; clear_obs();
    repeat (6) step();
    check("collide_press", 64'(press), 64'(5'b00100));
    event_ack = 1'b1; step(); event_ack = 1'b0;
    check("collide_mask", 64'({event_valid, event_mask}), 64'({1'b1, 5'b00100}));
    event_ack = 1'b1; step(); event_ack = 1'b0;
    check("ack_clear", 64'({event_valid, event_mask}), 64'd0);
    event_ack = 1'b1; step(); event_ack = 1'b0;
    check("ack_idle", 64'({event_valid, event_mask}), 64'd0);

    // simultaneous multi-bit press
    raw_in = '0; repeat (8) step();
    raw_in = 5'b11010; clear_obs();
    repeat (8) step();
    check("multi_press_b1", 64'(press_at[1]), 64'd5);
    check("multi_press_b3", 64'(press_at[3]), 64'd5);
    check("multi_press_b4", 64'(press_at[4]), 64'd5);
    check("multi_no_b0", 64'(press_cnt[0]), 64'd0);
    check("multi_mask", 64'(event_mask), 64'(5'b11010));

    // reset in the middle of a count
    raw_in = '0; repeat (8) step();
    event_ack = 1'b1; step(); event_ack = 1'b0;
    raw_in[3] = 1'b1; repeat (3) step();
    rst = 1'b0; step(); rst = 1'b1;
    check("midreset_outputs", 64'({stable, press, release_pulse, event_mask, event_valid}), 64'd0);
    clear_obs();
    repeat (8) step();
    check("midreset_press_edge", 64'(press_at[3]), 64'd5);
    check("midreset_press_count", 64'(press_cnt[3]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
